// File: rtl/mem_block_mover.sv
// Byte-wide DMA-style block mover: copies a RAM region (read/write pairs)
// or fills a region with a constant, one access per cycle, 16-bit wrapping pointers.
module mem_block_mover (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic [7:0]  fill_val,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_adr,
    output logic        mem_rwn,
    output logic        mem_cs,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  fill_q, fill_d;
    logic [15:0] cnt_dec;

    assign cnt_dec = cnt_q - 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= 16'd0;
            dst_q   <= 16'd0;
            cnt_q   <= 16'd0;
            fill_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_adr   = 16'd0;
        mem_rwn   = 1'b1;
        mem_cs    = 1'b0;
        mem_wdata = 8'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == 16'd0) begin
                        state_d = FIN;
                    end else begin
                        src_d   = src;
                        dst_d   = dst;
                        cnt_d   = len;
                        fill_d  = fill_val;
                        state_d = mode ? FILL : RD;
                    end
                end
            end
            RD: begin
                busy    = 1'b1;
                mem_cs  = 1'b1;
                mem_adr = src_q;
                state_d = WR;
            end
            WR: begin
                // RAM read data arrives this cycle and goes straight back out as write data
                busy      = 1'b1;
                mem_cs    = 1'b1;
                mem_rwn   = 1'b0;
                mem_adr   = dst_q;
                mem_wdata = mem_rdata;
                src_d     = src_q + 16'd1;
                dst_d     = dst_q + 16'd1;
                cnt_d     = cnt_dec;
                state_d   = (cnt_dec != 16'd0) ? RD : FIN;
            end
            FILL: begin
                busy      = 1'b1;
                mem_cs    = 1'b1;
                mem_rwn   = 1'b0;
                mem_adr   = dst_q;
                mem_wdata = fill_q;
                dst_d     = dst_q + 16'd1;
                cnt_d     = cnt_dec;
                state_d   = (cnt_dec != 16'd0) ? FILL : FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort lets the current access finish but drops the transfer without done
        if (abort && (state_q == RD || state_q == WR || state_q == FILL)) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover: a registered-read RAM model, a per-cycle
// vector table, and hand-written sequences for copy, fill wrap, zero length, abort and reset.
module tb_mem_block_mover;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [7:0]  fill_val;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] mem_adr;
    logic        mem_rwn;
    logic        mem_cs;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:65535];
    logic        poke_en;
    logic [15:0] poke_adr;
    logic [7:0]  poke_data;
    int          wr_count;
    int          cs_count;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        start;
        logic        mode;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [7:0]  fill;
        logic        abort;
        logic        e_busy;
        logic        e_done;
        logic        e_cs;
        logic        e_rwn;
        logic [15:0] e_adr;
        logic [7:0]  e_wdata;
        logic        chk_wdata;
    } vec_t;

    vec_t vecs [14];

    mem_block_mover dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_val  (fill_val),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_adr   (mem_adr),
        .mem_rwn   (mem_rwn),
        .mem_cs    (mem_cs),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read data, synchronous write, plus a bench preload port
    initial begin
        wr_count  = 0;
        cs_count  = 0;
        mem_rdata = 8'd0;
    end

    always @(posedge clk) begin
        if (poke_en) mem[poke_adr] <= poke_data;
        if (mem_cs) cs_count <= cs_count + 1;
        if (mem_cs && mem_rwn) mem_rdata <= mem[mem_adr];
        if (mem_cs && !mem_rwn) begin
            mem[mem_adr] <= mem_wdata;
            wr_count     <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_adr  = a;
        poke_data = d;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic clearOperands();
        start    = 1'b0;
        mode     = 1'b0;
        src      = 16'd0;
        dst      = 16'd0;
        len      = 16'd0;
        fill_val = 8'd0;
        abort    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset    = v.rst;
        start    = v.start;
        mode     = v.mode;
        src      = v.src;
        dst      = v.dst;
        len      = v.len;
        fill_val = v.fill;
        abort    = v.abort;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic startOp(input logic m, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] n, input logic [7:0] f);
        start    = 1'b1;
        mode     = m;
        src      = s;
        dst      = d;
        len      = n;
        fill_val = f;
        tick();
        clearOperands();
    endtask

    // Samples the current cycle first (index 1), then advances; done_at is 0 if done never seen
    task automatic runMonitor(input int ncycles, output int busy_cnt, output int done_cnt,
                              output int done_at, output int cs_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        cs_cnt   = 0;
        for (int i = 1; i <= ncycles; i++) begin
            if (busy) busy_cnt++;
            if (mem_cs) cs_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            tick();
        end
    endtask

    initial begin
        int bc, dc, da, cc;
        int wc0;
        int wr_seen;
        int guard;
        int done_seen;

        checks   = 0;
        errors   = 0;
        poke_en  = 1'b0;
        poke_adr = 16'd0;
        poke_data = 8'd0;
        reset    = 1'b1;
        clearOperands();

        poke(16'h0300, 8'h77);
        for (int j = 0; j < 4; j++) begin
            poke(16'h1000 + 16'(j), 8'h11 * 8'(j + 1));
        end

        //            rst  st   md   src       dst       len    fill   ab   bsy  dn   cs   rwn  adr       wdata  chkw
        vecs[0]  = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[1]  = '{1'b0,1'b1,1'b1,16'h0000,16'h0010,16'd2, 8'h5A,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0010,8'h5A,1'b1};
        vecs[2]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0011,8'h5A,1'b1};
        vecs[3]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[4]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[5]  = '{1'b0,1'b1,1'b0,16'h0300,16'h0400,16'd1, 8'h00,1'b0,1'b1,1'b0,1'b1,1'b1,16'h0300,8'h00,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0400,8'h77,1'b1};
        vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[8]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[9]  = '{1'b0,1'b1,1'b0,16'h1234,16'h5678,16'd0, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000,8'h00,1'b1};
        vecs[12] = '{1'b0,1'b1,1'b1,16'h0000,16'h0020,16'd1, 8'hC3,1'b1,1'b1,1'b0,1'b1,1'b0,16'h0020,8'hC3,1'b1};
        vecs[13] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0, 8'h00,1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000,8'h00,1'b1};

        // Outputs packed as {busy, done, cs, rwn, adr, wdata} after each edge
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d", i),
                        {4'd0, busy, done, mem_cs, mem_rwn, mem_adr, vecs[i].chk_wdata ? mem_wdata : 8'h00},
                        {4'd0, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cs, vecs[i].e_rwn,
                         vecs[i].e_adr, vecs[i].e_wdata});
        end
        clearOperands();
        tick();

        // Copy of four bytes
        startOp(1'b0, 16'h1000, 16'h2000, 16'd4, 8'h00);
        runMonitor(20, bc, dc, da, cc);
        checkOutput("copy_done_cycle", 32'(da), 32'd9);
        checkOutput("copy_busy_cycles", 32'(bc), 32'd8);
        checkOutput("copy_done_count", 32'(dc), 32'd1);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("copy_byte%0d", j), 32'(mem[16'h2000 + 16'(j)]), 32'(8'h11 * 8'(j + 1)));
        end

        // Fill across the top of the address space
        poke(16'hFFFE, 8'h00);
        poke(16'hFFFF, 8'h00);
        poke(16'h0000, 8'h00);
        poke(16'h0001, 8'h00);
        poke(16'h0002, 8'h3C);
        startOp(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'hA5);
        runMonitor(12, bc, dc, da, cc);
        checkOutput("wrap_done_cycle", 32'(da), 32'd5);
        checkOutput("wrap_busy_cycles", 32'(bc), 32'd4);
        checkOutput("wrap_FFFE", 32'(mem[16'hFFFE]), 32'h0A5);
        checkOutput("wrap_FFFF", 32'(mem[16'hFFFF]), 32'h0A5);
        checkOutput("wrap_0000", 32'(mem[16'h0000]), 32'h0A5);
        checkOutput("wrap_0001", 32'(mem[16'h0001]), 32'h0A5);
        checkOutput("wrap_0002_untouched", 32'(mem[16'h0002]), 32'h03C);

        // Zero length: done next cycle, no RAM activity
        startOp(1'b0, 16'h1000, 16'h2000, 16'd0, 8'h00);
        runMonitor(6, bc, dc, da, cc);
        checkOutput("zero_done_cycle", 32'(da), 32'd1);
        checkOutput("zero_busy_cycles", 32'(bc), 32'd0);
        checkOutput("zero_cs_cycles", 32'(cc), 32'd0);

        // Abort on the third write of a 16-byte copy
        for (int j = 0; j < 4; j++) begin
            poke(16'h3000 + 16'(j), 8'(j + 1));
            poke(16'h4000 + 16'(j), 8'hEE);
        end
        wc0 = wr_count;
        done_seen = 0;
        wr_seen = 0;
        guard = 0;
        startOp(1'b0, 16'h3000, 16'h4000, 16'd16, 8'h00);
        while (wr_seen < 3 && guard < 20) begin
            if (done) done_seen++;
            if (mem_cs && !mem_rwn) wr_seen++;
            if (wr_seen < 3) tick();
            guard++;
        end
        checkOutput("abort_reached_wr3", 32'(wr_seen), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_idle_outputs", {28'd0, busy, done, mem_cs, mem_rwn}, 32'h1);
        checkOutput("abort_write_count", 32'(wr_count - wc0), 32'd3);
        runMonitor(0, bc, dc, da, cc);
        checkOutput("abort_byte0", 32'(mem[16'h4000]), 32'h01);
        checkOutput("abort_byte1", 32'(mem[16'h4001]), 32'h02);
        checkOutput("abort_byte2", 32'(mem[16'h4002]), 32'h03);
        checkOutput("abort_byte3_untouched", 32'(mem[16'h4003]), 32'hEE);
        startOp(1'b1, 16'h0000, 16'h5000, 16'd1, 8'h99);
        checkOutput("restart_after_abort", {11'd0, busy, mem_cs, mem_rwn, mem_adr, mem_wdata},
                    {11'd0, 1'b1, 1'b1, 1'b0, 16'h5000, 8'h99});
        runMonitor(4, bc, dc, da, cc);
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);
        checkOutput("restart_done_cycle", 32'(da), 32'd2);

        // Start pulse during a fill must be ignored
        for (int j = 0; j < 4; j++) begin
            poke(16'h6000 + 16'(j), 8'h00);
        end
        poke(16'h7000, 8'h00);
        poke(16'h7001, 8'h00);
        startOp(1'b1, 16'h0000, 16'h6000, 16'd4, 8'h42);
        tick();
        startOp(1'b0, 16'h1000, 16'h7000, 16'd2, 8'h13);
        runMonitor(10, bc, dc, da, cc);
        checkOutput("ignored_done_cycle", 32'(da), 32'd3);
        checkOutput("ignored_done_count", 32'(dc), 32'd1);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("ignored_fill%0d", j), 32'(mem[16'h6000 + 16'(j)]), 32'h42);
        end
        checkOutput("ignored_7000", 32'(mem[16'h7000]), 32'h00);
        checkOutput("ignored_7001", 32'(mem[16'h7001]), 32'h00);

        // Reset during the second RD of a copy
        for (int j = 0; j < 4; j++) begin
            poke(16'h8000 + 16'(j), 8'h00);
        end
        wc0 = wr_count;
        startOp(1'b0, 16'h1000, 16'h8000, 16'd4, 8'h00);
        tick();
        tick();
        checkOutput("reset_in_rd", {15'd0, mem_cs, mem_adr}, {15'd0, 1'b1, 16'h1001});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("reset_outputs", {11'd0, busy, done, mem_cs, mem_rwn, mem_adr, mem_wdata},
                    {11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00});
        runMonitor(8, bc, dc, da, cc);
        checkOutput("reset_no_done", 32'(dc), 32'd0);
        checkOutput("reset_no_cs", 32'(cc), 32'd0);
        checkOutput("reset_write_count", 32'(wr_count - wc0), 32'd1);
        checkOutput("reset_byte0", 32'(mem[16'h8000]), 32'h11);
        checkOutput("reset_byte1_untouched", 32'(mem[16'h8001]), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
MEM_BLOCK_MOVER -- requirements
Module: mem_block_mover

Interface
REQ-001 The block SHALL have no parameters; address width is fixed at 16 and data width at 8.
REQ-002 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy (src to dst), 1 = fill (fill_val to dst); captured at start.
REQ-006 src  input  16  copy source base address; captured at start.
REQ-007 dst  input  16  destination base address; captured at start.
REQ-008 len  input  16  byte count; 0 = no transfer; captured at start.
REQ-009 fill_val  input  8  fill byte; captured at start.
REQ-010 abort  input  1  terminate the running transfer.
REQ-011 busy  output  1  high from the cycle after an accepted start until the transfer ends.
REQ-012 done  output  1  one-cycle completion pulse; not raised on abort.
REQ-013 mem_adr  output  16  RAM address.
REQ-014 mem_rwn  output  1  1 = read, 0 = write.
REQ-015 mem_cs  output  1  RAM select; a write happens only with mem_cs=1 and mem_rwn=0.
REQ-016 mem_wdata  output  8  RAM write data.
REQ-017 mem_rdata  input  8  RAM read data, registered by the RAM: valid in the cycle after the address is presented.

Function
REQ-018 States SHALL be IDLE, RD, WR, FILL and FIN.
REQ-019 IDLE: start=1 with len!=0 SHALL capture mode/src/dst/len/fill_val and go to RD (mode 0) or FILL (mode 1); start=1 with len=0 SHALL go to FIN with no memory access.
REQ-020 RD: mem_adr=src pointer, mem_rwn=1, mem_cs=1; next state SHALL be WR.
REQ-021 WR: mem_adr=dst pointer, mem_rwn=0, mem_cs=1, mem_wdata=mem_rdata (combinational pass-through); at the edge both pointers +1, remaining count -1; next state SHALL be RD if remaining after decrement !=0, else FIN.
REQ-022 FILL: mem_adr=dst pointer, mem_rwn=0, mem_cs=1, mem_wdata=captured fill_val; dst +1, count -1 per cycle; next state SHALL be FIN when the count reaches 0.
REQ-023 FIN: done=1, busy=0, mem_cs=0 for exactly one cycle; next state SHALL be IDLE.
REQ-024 In IDLE and FIN: mem_cs=0, mem_rwn=1, mem_adr=0, mem_wdata=0.
REQ-025 busy SHALL be 1 in RD, WR and FILL, and 0 in IDLE and FIN.
REQ-026 Latency: start sampled at edge k -> first access in cycle k+1; copy of N bytes takes cycles k+1..k+2N with done in cycle k+2N+1; fill of N bytes takes k+1..k+N with done in cycle k+N+1.
REQ-027 Pointers SHALL wrap modulo 65536 (0xFFFF+1 = 0x0000); no error is flagged.
REQ-028 Copy SHALL be strictly ascending and byte-sequential; overlapping regions with dst>src SHALL propagate already-written bytes (no memmove semantics).
REQ-029 start while busy or in FIN SHALL be ignored and SHALL NOT alter the captured operands.
REQ-030 abort=1 in RD, WR or FILL SHALL force IDLE at the next edge; the access driven in the abort cycle completes, no further access occurs and done stays 0; abort in IDLE/FIN SHALL have no effect.
REQ-031 abort and reset SHALL take priority over all state transitions, with reset highest.

Reset
REQ-032 reset=1 SHALL force IDLE at the next edge: busy=0, done=0, mem_cs=0, mem_rwn=1, mem_adr=0, mem_wdata=0, and internal pointers and count cleared.
REQ-033 Reset mid-transfer SHALL drop the transfer without done; any write presented in the reset cycle SHALL complete, and no later write SHALL occur.

Verification
REQ-034 Copy: RAM[0x1000..0x1003]=11,22,33,44; start mode=0 src=0x1000 dst=0x2000 len=4 -> RAM[0x2000..0x2003]=11,22,33,44; done exactly 8 cycles after the first access cycle; busy high for 8 cycles.
REQ-035 Fill wrap: mode=1 dst=0xFFFE len=4 fill_val=0xA5 -> 0xFFFE, 0xFFFF, 0x0000 and 0x0001 = 0xA5; done in cycle k+5.
REQ-036 Zero length: start len=0 -> no mem_cs assertion; done=1 in cycle k+1; busy never high.
REQ-037 Abort: copy len=16 with abort asserted on the 3rd WR cycle -> exactly 3 bytes written, done never asserted, back in IDLE; a new start is accepted the next cycle.
REQ-038 Ignored start: pulse start with different operands during a fill -> original fill completes unchanged and only one done pulse occurs.
REQ-039 Reset mid-operation: assert reset during a copy RD cycle -> next cycle all outputs are at reset values and there is no further memory write.
